// File: rtl/ram_rd_streamer.sv
// Streams a block of consecutive RAM words out as a valid/ready stream with a last marker.
// Optional macro RDS_STALL_CNT_EN adds a saturating stall_cnt output.
module ram_rd_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_renb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef RDS_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_addrb_hold;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [RD_LATENCY-1:0]   r_tag;
    logic [RD_LATENCY-1:0]   r_tag_last;
    logic [DATA_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
    logic                    r_mem_last [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic                    r_m_valid;
    logic                    r_m_last;
    logic                    r_done;

    logic                    w_renb;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_push_last;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_done_nxt;
    logic [SW-1:0]           w_inflight;
    logic [SW-1:0]           w_occ;
    logic [PW-1:0]           w_rd_nxt;
    logic [CW-1:0]           w_count_nxt;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_head_last;

    assign w_renb      = (r_state != S_IDLE);
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_push      = w_renb && r_tag[RD_LATENCY-1];
    assign w_push_last = r_tag_last[RD_LATENCY-1];
    assign w_pop       = r_m_valid && m_ready;

    // Credit check: occupancy is taken net of this cycle's pop so a steadily
    // drained stream sustains one read per cycle.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_tag[i]);
        end
        w_occ        = SW'(r_count) - SW'(w_pop);
        w_issue      = (r_state == S_RUN) && ((w_inflight + w_occ) < SW'(FIFO_DEPTH));
        w_issue_last = w_issue && (r_remaining == (ADDR_WIDTH + 1)'(1));
    end

    assign ram_addrb = w_issue ? r_addr : r_addrb_hold;
    assign ram_renb  = w_renb;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (length != '0)) begin
                    w_state_nxt = S_RUN;
                end else if (start) begin
                    w_done_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_m_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next FIFO head; a push into an emptying FIFO bypasses straight to the output.
    always_comb begin
        w_rd_nxt    = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_data = ram_doutb;
            w_head_last = w_push_last;
        end else begin
            w_head_data = r_mem_data[w_rd_nxt];
            w_head_last = r_mem_last[w_rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_addrb_hold <= '0;
            r_remaining  <= '0;
            r_tag        <= '0;
            r_tag_last   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_addr       <= r_addr + ADDR_WIDTH'(1);
                r_remaining  <= r_remaining - (ADDR_WIDTH + 1)'(1);
                r_addrb_hold <= r_addr;
            end
            if (w_renb) begin
                r_tag      <= (r_tag << 1) | RD_LATENCY'(w_issue);
                r_tag_last <= (r_tag_last << 1) | RD_LATENCY'(w_issue_last);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr  <= w_rd_nxt;
            r_count   <= w_count_nxt;
            r_m_valid <= (w_count_nxt != '0);
            r_m_data  <= w_head_data;
            r_m_last  <= w_head_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= ram_doutb;
            r_mem_last[r_wr_ptr] <= w_push_last;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

    assign busy    = w_renb;
    assign done    = r_done;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;

`ifdef RDS_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !m_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer with a latency-3 RAM model and a beat scoreboard.
module tb_ram_rd_streamer;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addrb;
    logic          ram_renb;
    logic [DW-1:0] ram_doutb;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
`ifdef RDS_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    ram_rd_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addrb (ram_addrb),
        .ram_renb  (ram_renb),
        .ram_doutb (ram_doutb),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
`ifdef RDS_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: three renb-gated stages from address to data
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rpipe [3];
    always @(posedge clk) begin
        if (ram_renb) begin
            rpipe[0] <= mem[ram_addrb];
            rpipe[1] <= rpipe[0];
            rpipe[2] <= rpipe[1];
        end
    end
    assign ram_doutb = rpipe[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW:0]   exp_q[$];
    int            beat_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            beats = 0;
    int            issued = 0;
    logic [AW-1:0] prev_addr = '0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(prev_data));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(m_data), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e[DW-1:0]));
                    chk("beat_last", 64'(m_last), 64'(e[DW]));
                end
                beats++;
                beat_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            if (ram_renb && (ram_addrb != prev_addr)) issued++;
            prev_addr = ram_addrb;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] len);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        length    = len;
        for (int i = 0; i < int'(len); i++) begin
            a = b + AW'(i);
            exp_q.push_back({(i == int'(len) - 1), 32'(a)});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; (k < budget) && (done_cnt == d0); k++) @(posedge clk);
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b1;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addrb", 64'(ram_addrb), 64'd0);
        chk("rst_renb", 64'(ram_renb), 64'd0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mlast", 64'(m_last), 64'd0);
`ifdef RDS_STALL_CNT_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic 8-word burst at full throughput
        beat_cyc.delete();
        d0 = done_cnt;
        run_cmd(10'h010, 11'd8);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(d0, 200);
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t1_beats", 64'(beat_cyc.size()), 64'd8);
        if (beat_cyc.size() == 8) begin
            chk("t1_consecutive", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);
            chk("t1_done_after_last", 64'(done_cyc - beat_cyc[7]), 64'd1);
        end
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Address wrap
        d0 = done_cnt;
        run_cmd(10'h3FE, 11'd4);
        wait_done(d0, 200);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-pressure: sink stalls for 20 cycles after the first valid
        d0 = done_cnt;
        m_ready = 1'b0;
        issued  = 0;
        run_cmd(10'h100, 11'd8);
        for (int k = 0; k < 100; k++) begin
            if (m_valid) break;
            @(posedge clk); #1;
        end
        chk("t3_first_valid", 64'(m_valid), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_issued_during_stall", 64'(issued), 64'(DEPTH));
        m_ready = 1'b1;
        wait_done(d0, 200);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t3_done_once", 64'(done_cnt - d0), 64'd1);
`ifdef RDS_STALL_CNT_EN
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd20);
`endif

        // Zero-length command
        b0 = beats;
        run_cmd(10'h020, 11'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_renb", 64'(ram_renb), 64'd0);
        chk("t4_mvalid", 64'(m_valid), 64'd0);
`ifdef RDS_STALL_CNT_EN
        chk("t4_stall_cleared", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        chk("t4_done_pulse", 64'(done), 64'd0);
        chk("t4_renb_later", 64'(ram_renb), 64'd0);
        chk("t4_no_beats", 64'(beats - b0), 64'd0);

        // Start while busy is ignored
        d0 = done_cnt;
        b0 = beats;
        run_cmd(10'h200, 11'd4);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 10'h300;
        length    = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, 200);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t5_beats", 64'(beats - b0), 64'd4);
        chk("t5_busy_idle", 64'(busy), 64'd0);

        // Reset in the middle of a burst
        d0 = done_cnt;
        b0 = beats;
        run_cmd(10'h040, 11'd8);
        for (int k = 0; (k < 200) && (beats - b0 < 3); k++) @(posedge clk);
        #1;
        chk("t6_three_beats", 64'(beats - b0), 64'd3);
        rst = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_addrb", 64'(ram_addrb), 64'd0);
        chk("t6_renb", 64'(ram_renb), 64'd0);
        chk("t6_mdata", 64'(m_data), 64'd0);
        chk("t6_mvalid", 64'(m_valid), 64'd0);
        chk("t6_mlast", 64'(m_last), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_idle_valid", 64'(m_valid), 64'd0);

        d0 = done_cnt;
        b0 = beats;
        run_cmd(10'h050, 11'd2);
        wait_done(d0, 200);
        chk("t7_beats", 64'(beats - b0), 64'd2);
        chk("t7_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t7_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
